// File: rtl/pipe_pkg.sv
// Shared lane payload layout and constants for the issue-to-commit skid stage.
// The stage itself moves lanes as flat DATA_W vectors; this struct names the fields.
package pipe_pkg;

   localparam int PC_W        = 32;
   localparam int WR_DATA_W   = 32;
   localparam int HI_W        = 32;
   localparam int LO_W        = 32;
   localparam int WR_ADDR_W   = 5;
   localparam int HILO_WE_W   = 2;
   localparam int CP0_ADDR_W  = 8;
   localparam int TLB_FLAGS_W = 15;

   typedef struct packed {
      logic [PC_W-1:0]        pc;
      logic [HI_W-1:0]        hi;
      logic [LO_W-1:0]        lo;
      logic [WR_DATA_W-1:0]   wr_data;
      logic [WR_ADDR_W-1:0]   wr_addr;
      logic                   wr_en;
      logic [HILO_WE_W-1:0]   hilo_we;
      logic [CP0_ADDR_W-1:0]  cp0_addr;
      logic                   cp0_we;
      logic [TLB_FLAGS_W-1:0] tlb_flags;
   } lane_payload_t;

   localparam int            LANE_PAYLOAD_W = $bits(lane_payload_t);
   localparam lane_payload_t LANE_ZERO      = '0;
   localparam logic [1:0]    OCC_EMPTY      = 2'd0;
   localparam logic [31:0]   STALL_MAX      = 32'hFFFF_FFFF;

   // Beats held = main + skid; both flags are single bits so the sum fits in 2 bits.
   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/lane_squash.sv
// Younger-lane kill mask: a lane survives only if it is valid and no older
// valid lane carries an exception. The excepting lane itself is kept.
module lane_squash #(
   parameter int LANES = 2
) (
   input  logic [LANES-1:0] lane_valid,
   input  logic [LANES-1:0] lane_excp,
   output logic [LANES-1:0] lane_keep
);

   logic [LANES-1:0] kill;

   assign kill[0] = 1'b0;

   genvar j;
   generate
      for (j = 1; j < LANES; j++) begin : g_kill
         assign kill[j] = kill[j-1] | (lane_valid[j-1] & lane_excp[j-1]);
      end
   endgenerate

   assign lane_keep = lane_valid & ~kill;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry (main + skid) pipeline register carrying LANES issue lanes per beat,
// with capture-time younger-lane squash, flush, occupancy and stall counting.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = LANE_PAYLOAD_W,
   parameter int LANES  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES-1:0]        in_lane_valid,
   input  logic [LANES-1:0]        in_lane_excp,
   input  logic [LANES*DATA_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES-1:0]        out_lane_valid,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [1:0]              occupancy,
   output logic [31:0]             stall_cnt
);

   // Handshake: a beat transfers on a rising edge where valid && ready are both
   // high; valid never waits on ready, and a presented beat is held until taken.
   // in_ready is registered (no combinational path from out_ready upstream).

   logic [LANES-1:0]        keep;
   logic [LANES*DATA_W-1:0] cap_data;

   logic [LANES-1:0]        main_lv_q, main_lv_n;
   logic [LANES*DATA_W-1:0] main_data_q, main_data_n;
   logic [LANES-1:0]        skid_lv_q, skid_lv_n;
   logic [LANES*DATA_W-1:0] skid_data_q, skid_data_n;
   logic                    in_ready_q;
   logic [1:0]              occ_q;
   logic [31:0]             stall_cnt_q;

   logic main_valid, skid_valid;
   logic accept, store, drain, stall_inc;

   lane_squash #(
      .LANES(LANES)
   ) u_lane_squash (
      .lane_valid(in_lane_valid),
      .lane_excp (in_lane_excp),
      .lane_keep (keep)
   );

   // Squashed lanes are stored as zero so nothing stale leaks downstream.
   always_comb begin
      cap_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (keep[i]) cap_data[i*DATA_W +: DATA_W] = in_data[i*DATA_W +: DATA_W];
      end
   end

   assign main_valid = |main_lv_q;
   assign skid_valid = |skid_lv_q;
   assign accept     = in_valid && in_ready_q;
   assign store      = accept && (|keep);
   assign drain      = main_valid && out_ready;
   assign stall_inc  = !flush && main_valid && !out_ready && (stall_cnt_q != STALL_MAX);

   always_comb begin
      main_lv_n   = main_lv_q;
      main_data_n = main_data_q;
      skid_lv_n   = skid_lv_q;
      skid_data_n = skid_data_q;
      if (flush) begin
         main_lv_n   = '0;
         main_data_n = '0;
         skid_lv_n   = '0;
         skid_data_n = '0;
      end else if (drain) begin
         if (skid_valid) begin
            // in_ready is low whenever skid is full, so no capture competes here.
            main_lv_n   = skid_lv_q;
            main_data_n = skid_data_q;
            skid_lv_n   = '0;
            skid_data_n = '0;
         end else if (store) begin
            main_lv_n   = keep;
            main_data_n = cap_data;
         end else begin
            main_lv_n   = '0;
            main_data_n = '0;
         end
      end else if (store) begin
         if (!main_valid) begin
            main_lv_n   = keep;
            main_data_n = cap_data;
         end else begin
            skid_lv_n   = keep;
            skid_data_n = cap_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         main_lv_q   <= '0;
         main_data_q <= '0;
         skid_lv_q   <= '0;
         skid_data_q <= '0;
         in_ready_q  <= 1'b0;
         occ_q       <= OCC_EMPTY;
         stall_cnt_q <= '0;
      end else begin
         main_lv_q   <= main_lv_n;
         main_data_q <= main_data_n;
         skid_lv_q   <= skid_lv_n;
         skid_data_q <= skid_data_n;
         in_ready_q  <= !(|skid_lv_n);
         occ_q       <= occ_count(|main_lv_n, |skid_lv_n);
         if (stall_inc) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_valid      = main_valid;
   assign out_lane_valid = main_lv_q;
   assign out_data       = main_data_q;
   assign occupancy      = occ_q;
   assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: stimulus pushes expected beats into a queue,
// an independent monitor pops and compares on every output handshake.
module tb_pipe_skid_stage;

   localparam int DATA_W = 160;
   localparam int LANES  = 2;
   localparam int BEAT_W = LANES + LANES * DATA_W;

   logic                    clk = 1'b0;
   logic                    rst = 1'b0;
   logic                    flush = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [LANES-1:0]        in_lane_valid = '0;
   logic [LANES-1:0]        in_lane_excp = '0;
   logic [LANES*DATA_W-1:0] in_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b0;
   logic [LANES-1:0]        out_lane_valid;
   logic [LANES*DATA_W-1:0] out_data;
   logic [1:0]              occupancy;
   logic [31:0]             stall_cnt;

   logic [BEAT_W-1:0] exp_q[$];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pipe_skid_stage #(
      .DATA_W(DATA_W),
      .LANES (LANES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_lane_valid (in_lane_valid),
      .in_lane_excp  (in_lane_excp),
      .in_data       (in_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_lane_valid(out_lane_valid),
      .out_data      (out_data),
      .occupancy     (occupancy),
      .stall_cnt     (stall_cnt)
   );

   function automatic logic [DATA_W-1:0] pat(input logic [7:0] t);
      return {20{t}};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      in_lane_valid = '0;
      in_lane_excp  = '0;
      in_data       = '0;
   endtask

   // Drive one beat; exp_lv is the hand-derived surviving lane mask.
   task automatic present(input logic [1:0] lv, input logic [1:0] ex, input logic [7:0] t0,
                          input logic [7:0] t1, input logic [1:0] exp_lv, input bit push);
      logic [BEAT_W-1:0] e;
      in_valid      = 1'b1;
      in_lane_valid = lv;
      in_lane_excp  = ex;
      in_data       = {pat(t1), pat(t0)};
      e = '0;
      e[LANES*DATA_W +: LANES] = exp_lv;
      if (exp_lv[0]) e[0 +: DATA_W] = pat(t0);
      if (exp_lv[1]) e[DATA_W +: DATA_W] = pat(t1);
      if (push && exp_lv != 2'b00) exp_q.push_back(e);
   endtask

   task automatic send(input logic [1:0] lv, input logic [1:0] ex, input logic [7:0] t0,
                       input logic [7:0] t1, input logic [1:0] exp_lv, input bit push);
      int n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check("send_in_ready", {63'd0, in_ready}, 64'd1);
      present(lv, ex, t0, t1, exp_lv, push);
      step();
      idle();
   endtask

   // Monitor: scoreboard pop on handshake, plus hold-stable check across stalls.
   initial begin
      logic              stall_seen;
      logic [BEAT_W-1:0] held, cur, e;
      stall_seen = 1'b0;
      held       = '0;
      forever begin
         @(negedge clk);
         cur = {out_lane_valid, out_data};
         if (stall_seen) begin
            total++;
            if (cur !== held) begin
               bad++;
               $display("FAIL hold_stable: got %h expected %h", cur, held);
            end
         end
         if (rst && !flush && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL scoreboard_extra: got %h expected none", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  bad++;
                  $display("FAIL scoreboard_beat: got %h expected %h", cur, e);
               end
            end
         end
         stall_seen = rst && !flush && out_valid && !out_ready;
         held       = cur;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      // Reset state
      idle();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_occupancy", {62'd0, occupancy}, 64'd0);
      check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
      check("rst_out_data_nz", {63'd0, |{out_lane_valid, out_data}}, 64'd0);
      step();
      rst = 1'b1;
      step();
      check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      // Stall counter: one beat held for 10 stalled edges
      out_ready = 1'b0;
      send(2'b11, 2'b00, 8'h11, 8'h12, 2'b11, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("stall10_cnt", {32'd0, stall_cnt}, 64'd10);
      check("stall10_occ", {62'd0, occupancy}, 64'd1);
      step();
      step();

      // Back-to-back, out_ready high
      for (int i = 0; i < 4; i++) begin
         check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
         present(2'b11, 2'b00, 8'h20 + 8'(2*i), 8'h21 + 8'(2*i), 2'b11, 1'b1);
         @(negedge clk);
         check("b2b_occ_le1", {63'd0, occupancy > 2'd1}, 64'd0);
         if (i > 0) check("b2b_out_valid", {63'd0, out_valid}, 64'd1);
         step();
      end
      idle();
      @(negedge clk);
      check("b2b_last_valid", {63'd0, out_valid}, 64'd1);
      step();
      @(negedge clk);
      check("b2b_empty", {62'd0, occupancy}, 64'd0);

      // Kill mask and bubble
      step();
      send(2'b11, 2'b01, 8'hA1, 8'hA2, 2'b01, 1'b1);
      send(2'b11, 2'b10, 8'hB1, 8'hB2, 2'b11, 1'b1);
      send(2'b11, 2'b11, 8'hC1, 8'hC2, 2'b01, 1'b1);
      send(2'b10, 2'b00, 8'hD1, 8'hD2, 2'b10, 1'b1);
      send(2'b01, 2'b01, 8'hD3, 8'hD4, 2'b01, 1'b1);
      send(2'b00, 2'b11, 8'hE1, 8'hE2, 2'b00, 1'b1);
      @(negedge clk);
      check("bubble_out_valid", {63'd0, out_valid}, 64'd0);
      check("bubble_occ", {62'd0, occupancy}, 64'd0);

      // Skid: A then B with downstream stalled
      step();
      out_ready = 1'b0;
      send(2'b11, 2'b00, 8'h31, 8'h32, 2'b11, 1'b1);
      send(2'b11, 2'b00, 8'h41, 8'h42, 2'b11, 1'b1);
      @(negedge clk);
      check("skid_occ", {62'd0, occupancy}, 64'd2);
      check("skid_in_ready", {63'd0, in_ready}, 64'd0);
      check("skid_out_valid", {63'd0, out_valid}, 64'd1);
      step();
      out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      check("skid_drained_occ", {62'd0, occupancy}, 64'd0);
      check("skid_drained_rdy", {63'd0, in_ready}, 64'd1);
      check("skid_stall_cnt", {32'd0, stall_cnt}, 64'd12);

      // Flush with occupancy 2 and in_valid high
      step();
      out_ready = 1'b0;
      send(2'b11, 2'b00, 8'h51, 8'h52, 2'b11, 1'b1);
      send(2'b11, 2'b00, 8'h61, 8'h62, 2'b11, 1'b1);
      present(2'b11, 2'b00, 8'h71, 8'h72, 2'b11, 1'b0);
      flush = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("flush_pre_occ", {62'd0, occupancy}, 64'd2);
      step();
      flush = 1'b0;
      idle();
      @(negedge clk);
      check("flush_out_valid", {63'd0, out_valid}, 64'd0);
      check("flush_occ", {62'd0, occupancy}, 64'd0);
      check("flush_in_ready", {63'd0, in_ready}, 64'd1);
      check("flush_stall_cnt", {32'd0, stall_cnt}, 64'd13);
      check("flush_data_nz", {63'd0, |{out_lane_valid, out_data}}, 64'd0);

      // Flush drops a beat accepted in the same cycle
      step();
      send(2'b11, 2'b00, 8'h81, 8'h82, 2'b11, 1'b0);
      present(2'b11, 2'b00, 8'h91, 8'h92, 2'b11, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      check("flush2_pre_occ", {62'd0, occupancy}, 64'd1);
      check("flush2_pre_rdy", {63'd0, in_ready}, 64'd1);
      step();
      flush = 1'b0;
      idle();
      @(negedge clk);
      check("flush2_occ", {62'd0, occupancy}, 64'd0);
      check("flush2_stall_cnt", {32'd0, stall_cnt}, 64'd13);
      step();
      @(negedge clk);
      check("flush2_no_ghost", {63'd0, out_valid}, 64'd0);

      // Saturation from a preset near max
      step();
      send(2'b01, 2'b00, 8'hF1, 8'hF2, 2'b01, 1'b1);
      @(negedge clk);
      dut.stall_cnt_q = 32'hFFFF_FFFD;
      step();
      @(negedge clk);
      check("sat_step", {32'd0, stall_cnt}, 64'hFFFF_FFFE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("sat_hold", {32'd0, stall_cnt}, 64'hFFFF_FFFF);

      // Reset mid-stall with both entries full
      step();
      send(2'b11, 2'b00, 8'hC5, 8'hC6, 2'b11, 1'b1);
      @(negedge clk);
      check("rst_mid_pre_occ", {62'd0, occupancy}, 64'd2);
      step();
      rst = 1'b0;
      exp_q.delete();
      step();
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_mid_occ", {62'd0, occupancy}, 64'd0);
      check("rst_mid_stall", {32'd0, stall_cnt}, 64'd0);
      check("rst_mid_in_ready", {63'd0, in_ready}, 64'd0);
      check("rst_mid_data_nz", {63'd0, |{out_lane_valid, out_data}}, 64'd0);
      step();
      check("rst_mid_ready_after", {63'd0, in_ready}, 64'd1);

      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
